// File: rtl/kernel3x3_filter.sv
// 3x3 neighbourhood filter with per-pixel selectable kernel (pass, box, gauss, sharpen) and saturation counter.
// Latency: 3 clk from valid_in to valid_out, one pixel per cycle.
// Backpressure: none; every valid_in is accepted and outputs hold while valid_out is low.
module kernel3x3_filter #(
    parameter int CW    = 4,
    parameter int NCH   = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [1:0]            mode,
    input  logic [9*NCH*CW-1:0]   window,
    input  logic                  sat_clr,
    output logic                  valid_out,
    output logic [NCH*CW-1:0]     filter_out,
    output logic [NCH*CW-1:0]     original_out,
    output logic [CNT_W-1:0]      sat_count
);
    localparam int PW    = NCH * CW;
    localparam int SW    = CW + 6;
    localparam int PWIDE = SW + 13;

    localparam logic [12:0]          BOX_MUL = 13'd7282;
    localparam logic signed [SW-1:0] MAXV    = SW'((1 << CW) - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = '1;

    localparam logic [1:0] M_PASS  = 2'd0;
    localparam logic [1:0] M_BOX   = 2'd1;
    localparam logic [1:0] M_GAUSS = 2'd2;

    // Stage 1: raw window capture
    logic            s1_vld;
    logic [1:0]      s1_mode;
    logic [9*PW-1:0] s1_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld  <= 1'b0;
            s1_mode <= 2'd0;
            s1_win  <= '0;
        end else begin
            s1_vld  <= valid_in;
            s1_mode <= mode;
            s1_win  <= window;
        end
    end

    // Stage 2 shared state: mode and centre pixel travel with the sums
    logic          s2_vld;
    logic [1:0]    s2_mode;
    logic [PW-1:0] s2_ctr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_vld  <= 1'b0;
            s2_mode <= 2'd0;
            s2_ctr  <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_mode <= s1_mode;
            s2_ctr  <= s1_win[4*PW +: PW];
        end
    end

    logic [PW-1:0]  filt_nxt;
    logic [NCH-1:0] clip_vec;

    genvar g, k;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            logic signed [SW-1:0] p [9];
            logic signed [SW-1:0] sum_c;
            logic signed [SW-1:0] s2_sum;
            logic [PWIDE-1:0]     prod;
            logic signed [SW-1:0] norm;
            logic [CW-1:0]        ch_val;
            logic                 ch_clip;

            for (k = 0; k < 9; k++) begin : g_px
                assign p[k] = SW'(s1_win[k*PW + g*CW +: CW]);
            end

            always_comb begin
                case (s1_mode)
                    M_PASS:  sum_c = p[4];
                    M_BOX:   sum_c = p[0] + p[1] + p[2] + p[3] + p[4]
                                   + p[5] + p[6] + p[7] + p[8];
                    M_GAUSS: sum_c = (p[0] + p[2] + p[6] + p[8])
                                   + ((p[1] + p[3] + p[5] + p[7]) <<< 1)
                                   + (p[4] <<< 2);
                    default: sum_c = (p[4] <<< 2) + p[4]
                                   - p[1] - p[3] - p[5] - p[7];
                endcase
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s2_sum <= '0;
                end else begin
                    s2_sum <= sum_c;
                end
            end

            // Box sums are never negative, so the /9 reciprocal multiply can stay unsigned
            assign prod = PWIDE'($unsigned(s2_sum)) * PWIDE'(BOX_MUL);

            always_comb begin
                case (s2_mode)
                    M_BOX:   norm = SW'(prod >> 16);
                    M_GAUSS: norm = s2_sum >>> 4;
                    default: norm = s2_sum;
                endcase
                ch_val  = norm[CW-1:0];
                ch_clip = 1'b0;
                if (norm[SW-1]) begin
                    ch_val  = '0;
                    ch_clip = 1'b1;
                end else if (norm > MAXV) begin
                    ch_val  = '1;
                    ch_clip = 1'b1;
                end
            end

            assign filt_nxt[g*CW +: CW] = ch_val;
            assign clip_vec[g]          = ch_clip;
        end
    endgenerate

    // Stage 3: output registers hold their value between valid pixels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out    <= 1'b0;
            filter_out   <= '0;
            original_out <= '0;
        end else begin
            valid_out <= s2_vld;
            if (s2_vld) begin
                filter_out   <= filt_nxt;
                original_out <= s2_ctr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (s2_vld && (|clip_vec) && (sat_count != CNT_MAX)) begin
            sat_count <= sat_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_kernel3x3_filter.sv
// Randomised and directed bench for kernel3x3_filter against an arithmetic kernel model.
module tb_kernel3x3_filter;
    localparam int CW    = 4;
    localparam int NCH   = 3;
    localparam int CNT_W = 16;
    localparam int PW    = NCH * CW;
    localparam int MAXV  = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 valid_in;
    logic [1:0]           mode;
    logic [9*PW-1:0]      window;
    logic                 sat_clr;
    logic                 valid_out;
    logic [PW-1:0]        filter_out;
    logic [PW-1:0]        original_out;
    logic [CNT_W-1:0]     sat_count;

    kernel3x3_filter #(.CW(CW), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .mode         (mode),
        .window       (window),
        .sat_clr      (sat_clr),
        .valid_out    (valid_out),
        .filter_out   (filter_out),
        .original_out (original_out),
        .sat_count    (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int            due;
        logic [PW-1:0] f;
        logic [PW-1:0] o;
        logic          clip;
    } exp_t;

    exp_t             q[$];
    int               cyc;
    int               n_assert;
    int               n_fail;
    logic [PW-1:0]    last_f;
    logic [PW-1:0]    last_o;
    logic [CNT_W-1:0] cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int weight(input logic [1:0] m, input int k);
        int w;
        case (m)
            2'd0:    w = (k == 4) ? 1 : 0;
            2'd1:    w = 1;
            2'd2:    w = (k == 4) ? 4 : ((k % 2) ? 2 : 1);
            default: w = (k == 4) ? 5 : ((k % 2) ? -1 : 0);
        endcase
        return w;
    endfunction

    function automatic void model(input logic [9*PW-1:0] w, input logic [1:0] m,
                                  output logic [PW-1:0] f, output logic clip);
        int s, n, dv;
        f    = '0;
        clip = 1'b0;
        dv   = (m == 2'd1) ? 9 : (m == 2'd2) ? 16 : 1;
        for (int ch = 0; ch < NCH; ch++) begin
            s = 0;
            for (int k = 0; k < 9; k++)
                s += weight(m, k) * int'(w[k*PW + ch*CW +: CW]);
            n = s / dv;
            if (n < 0) begin
                n = 0;
                clip = 1'b1;
            end else if (n > MAXV) begin
                n = MAXV;
                clip = 1'b1;
            end
            f[ch*CW +: CW] = CW'(n);
        end
    endfunction

    function automatic logic [9*PW-1:0] mkwin(input logic [PW-1:0] corner,
                                               input logic [PW-1:0] edge_p,
                                               input logic [PW-1:0] centre);
        logic [9*PW-1:0] w;
        for (int k = 0; k < 9; k++)
            w[k*PW +: PW] = (k == 4) ? centre : ((k % 2) ? edge_p : corner);
        return w;
    endfunction

    function automatic logic [9*PW-1:0] rndwin();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[9*PW-1:0];
    endfunction

    task automatic step(input logic v, input logic [1:0] m, input logic [9*PW-1:0] w, input logic clr);
        exp_t          e;
        logic [PW-1:0] f;
        logic          c;
        logic          ov;
        valid_in = v;
        mode     = m;
        window   = w;
        sat_clr  = clr;
        @(posedge clk);
        cyc++;
        if (v) begin
            model(w, m, f, c);
            e.due  = cyc + 2;
            e.f    = f;
            e.o    = w[4*PW +: PW];
            e.clip = c;
            q.push_back(e);
        end
        ov = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e      = q.pop_front();
            ov     = 1'b1;
            last_f = e.f;
            last_o = e.o;
            if (clr) cnt = '0;
            else if (e.clip && cnt != '1) cnt = cnt + 1'b1;
        end else if (clr) begin
            cnt = '0;
        end
        #1;
        chk("valid_out", 32'(valid_out), 32'(ov));
        chk("filter_out", 32'(filter_out), 32'(last_f));
        chk("original_out", 32'(original_out), 32'(last_o));
        chk("sat_count", 32'(sat_count), 32'(cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        valid_in = 1'b0;
        sat_clr  = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_filter", 32'(filter_out), 32'd0);
        chk("rst_original", 32'(original_out), 32'd0);
        chk("rst_sat", 32'(sat_count), 32'd0);
        q.delete();
        last_f = '0;
        last_o = '0;
        cnt    = '0;
        @(posedge clk);
        @(posedge clk);
        cyc += 2;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [9*PW-1:0] wins [6];
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        valid_in = 1'b0;
        mode     = 2'd0;
        window   = '0;
        sat_clr  = 1'b0;
        #2;
        do_reset();

        // single box pixel of all-ones: valid only at +3
        step(1'b1, 2'd1, mkwin(12'hFFF, 12'hFFF, 12'hFFF), 1'b0);
        idle(2);
        chk("box_ones_f", 32'(filter_out), 32'h0FFF);
        chk("box_ones_o", 32'(original_out), 32'h0FFF);
        chk("box_ones_sat", 32'(sat_count), 32'd0);
        idle(1);

        step(1'b1, 2'd1, mkwin(12'h000, 12'h000, 12'h900), 1'b0);
        idle(2);
        chk("box_red9_f", 32'(filter_out), 32'h0100);
        chk("box_red9_o", 32'(original_out), 32'h0900);

        step(1'b1, 2'd2, mkwin(12'h000, 12'h000, 12'h00F), 1'b0);
        idle(2);
        chk("gauss_blue", 32'(filter_out), 32'h0003);

        step(1'b1, 2'd3, mkwin(12'h000, 12'hFFF, 12'h888), 1'b0);
        idle(2);
        chk("sharp_low_f", 32'(filter_out), 32'h0000);
        chk("sharp_low_sat", 32'(sat_count), 32'd1);
        step(1'b1, 2'd3, mkwin(12'h000, 12'h000, 12'hFFF), 1'b0);
        idle(2);
        chk("sharp_high_f", 32'(filter_out), 32'h0FFF);
        chk("sharp_high_sat", 32'(sat_count), 32'd2);

        // back-to-back with mode cycling; pass-through results equal the centre pixel
        for (int j = 0; j < 8; j++) begin
            if (j < 6) begin
                wins[j] = rndwin();
                step(1'b1, 2'(j % 4), wins[j], 1'b0);
            end else begin
                step(1'b0, 2'd0, '0, 1'b0);
            end
            if (j >= 2 && ((j - 2) % 4) == 0)
                chk("pass_is_centre", 32'(filter_out), 32'(wins[j-2][4*PW +: PW]));
        end
        idle(1);

        // clear coincides with a clamping pixel reaching stage 3
        step(1'b1, 2'd3, mkwin(12'h000, 12'h000, 12'hFFF), 1'b0);
        idle(1);
        step(1'b0, 2'd0, '0, 1'b1);
        chk("clr_wins", 32'(sat_count), 32'd0);

        // reset with pixels in flight
        step(1'b1, 2'd3, mkwin(12'h000, 12'h000, 12'hFFF), 1'b0);
        step(1'b1, 2'd0, mkwin(12'h000, 12'h000, 12'hABC), 1'b0);
        step(1'b1, 2'd0, mkwin(12'h000, 12'h000, 12'h123), 1'b0);
        do_reset();
        idle(2);
        step(1'b1, 2'd0, rndwin(), 1'b0);
        idle(3);

        for (int i = 0; i < 80; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rndwin(),
                 $urandom_range(0, 9) == 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/kernel3x3_filter.md
Name: kernel3x3_filter

Overview:
- Parametrised successor to the fixed 3x3 box-average pixel filter in the image-processing datapath.
- Takes a packed 3x3 neighbourhood of NCH-channel pixels and applies a per-pixel selectable kernel: pass-through, box /9, Gaussian or sharpen.
- Three-stage pipeline with valid qualification and a centre-pixel output aligned to the result.
- Sits between the line-buffer window generator and the video output, and adds a saturation-event counter for debug.

Parameters:
- CW, 4, bits per colour channel.
- NCH, 3, channels per pixel; channel NCH-1 occupies the MS bits (red), channel 0 the LS bits (blue).
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  window and mode are valid this cycle.
- mode  in  2  kernel select: 0 pass, 1 box, 2 gauss, 3 sharpen; sampled with valid_in.
- window  in  9*NCH*CW  packed pixels, k=0..8 row-major (0 up-left, 4 centre, 8 down-right).
  - Pixel k occupies bits [(k+1)*PW-1 : k*PW], where PW = NCH*CW.
- sat_clr  in  1  synchronous clear of sat_count.
- valid_out  out  1  filter_out and original_out are valid.
- filter_out  out  NCH*CW  filtered pixel.
- original_out  out  NCH*CW  centre pixel (k=4) of the same window, aligned with filter_out.
- sat_count  out  CNT_W  number of output pixels with at least one clamped channel.

Behaviour:
- Reset (reset=0, asynchronous):
  - valid_out, filter_out, original_out, sat_count and all pipeline registers go to 0.
  - In-flight pixels are dropped.
  - valid_out stays 0 until 3 cycles after the first valid_in following release.
- Latency: exactly 3 clk cycles from a valid_in sample to valid_out.
- Throughput: one pixel per cycle; back-to-back valid_in is accepted every cycle; there is no backpressure.
- Mode travels with its pixel through the pipeline; changing mode every cycle is legal and each output uses its own mode.
- Stage 1: register window, mode and valid.
- Stage 2: per channel, compute a signed sum S of width CW+6.
  - mode 0: S = centre.
  - mode 1: S = sum of all 9 pixels.
  - mode 2: S = 1*corners + 2*edges + 4*centre.
  - mode 3: S = 5*centre - up(1) - left(3) - right(5) - down(7).
- Stage 3: per channel, normalise then clamp.
  - Normalise:
    - mode 1: N = (S*7282)>>16, an exact /9 for all legal sums; intermediate width is at least CW+4+13.
    - mode 2: N = S>>4, truncating.
    - modes 0 and 3: N = S.
  - Clamp: N<0 gives 0; N>2^CW-1 gives 2^CW-1.
  - Clamping can occur only in mode 3.
- When valid_out=0, filter_out and original_out hold their previous values.
- sat_count:
  - Increments by 1 on a stage-3 valid pixel with any channel clamped.
  - Saturates at 2^CW_N-1, where CW_N means CNT_W; it does not wrap.
  - sat_clr has priority: clear and increment in the same cycle gives 0, and that event is lost.
  - sat_clr does not affect the data path.

Test Plan (CW=4, NCH=3):
- All nine pixels 0xFFF, mode 1, single valid_in at cycle t -> valid_out=1 at exactly t+3 only; filter_out=0xFFF, original_out=0xFFF, sat_count=0.
- Centre 0x900, others 0x000, mode 1 -> red sum 9 -> filter_out=0x100; original_out=0x900.
- Centre 0x00F, others 0, mode 2 -> blue 60>>4=3 -> filter_out=0x003.
- Mode 3 clamping:
  - Centre 0x888, pixels 1,3,5,7 = 0xFFF -> 40-60<0 -> filter_out=0x000, sat_count=1.
  - Then centre 0xFFF, others 0 -> 75 clamps -> 0xFFF, sat_count=2.
- 6 back-to-back pixels with mode cycling 0,1,2,3,0,1 -> 6 consecutive valid_out cycles; each result matches its own mode; mode 0 output equals original_out.
- Back-to-back traffic:
  - Reset asserted mid-stream with 3 pixels in flight -> outputs 0 immediately; no valid_out until 3 cycles after the next valid_in.
  - sat_clr asserted in the same cycle as a clamping pixel -> sat_count=0.
